// File: rtl/servo_sweep_ctrl.sv
// servo_sweep_ctrl: frame-aligned servo position generator (track / sweep).
// Optional key debounce: define SERVO_SWEEP_DEBOUNCE_EN.
`timescale 1ns/1ps
module servo_sweep_ctrl #(
  parameter int FRAME_CYCLES    = 262144,
  parameter int STEP            = 1,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sweep_en,
  input  logic [7:0] target,
  input  logic       dir_key,
  output logic [7:0] position,
  output logic       dir,
  output logic       frame_tick
);

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam logic [FW-1:0] FLAST = FW'(FRAME_CYCLES - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] STEP8 = 8'(STEP);

  typedef enum logic {TRACK, SWEEP} state_t;

  state_t state, state_n;
  logic [FW-1:0] fcnt;
  logic [1:0] sync;
  logic key_lvl, key_prev, key_pulse;
  logic [7:0] pos_n;
  logic dir_n, rev;
  logic [8:0] d, mag, sum, diff;

  // Frame counter wraps every FRAME_CYCLES clocks.
  always_ff @(posedge clk) begin
    if (rst) fcnt <= '0;
    else if (frame_tick) fcnt <= '0;
    else fcnt <= fcnt + 1'b1;
  end

  assign frame_tick = (fcnt == FLAST);

  // Two-flop synchroniser for the raw pushbutton.
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b00;
    else sync <= {sync[0], dir_key};
  end

`ifdef SERVO_SWEEP_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  logic [DW-1:0] db_cnt;
  logic db_lvl;

  // Accept a new key level only after it has held steady long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (sync[1] == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DLAST) begin
      db_cnt <= '0;
      db_lvl <= sync[1];
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign key_lvl = db_lvl;
`else
  assign key_lvl = sync[1];
`endif

  // Previous key level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) key_prev <= 1'b0;
    else key_prev <= key_lvl;
  end

  assign key_pulse = key_lvl & ~key_prev;

  assign d    = {1'b0, target} - {1'b0, position};
  assign mag  = d[8] ? (~d + 9'd1) : d;
  assign sum  = {1'b0, position} + STEP9;
  assign diff = {1'b0, position} - STEP9;

  // State, position and direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TRACK;
      position <= 8'h7F;
      dir      <= 1'b1;
    end else begin
      state    <= state_n;
      position <= pos_n;
      dir      <= dir_n;
    end
  end

  // Mode select and per-frame position update; endpoint reversal beats key.
  always_comb begin
    state_n = state;
    pos_n   = position;
    dir_n   = dir;
    rev     = 1'b0;
    if (frame_tick) begin
      state_n = sweep_en ? SWEEP : TRACK;
      unique case (1'b1)
        (state_n == TRACK): begin
          if (mag <= STEP9) pos_n = target;
          else if (d[8]) pos_n = position - STEP8;
          else pos_n = position + STEP8;
        end
        (state_n == SWEEP): begin
          if (dir) begin
            pos_n = sum[8] ? 8'hFF : sum[7:0];
            if (pos_n == 8'hFF) begin
              dir_n = 1'b0;
              rev   = 1'b1;
            end
          end else begin
            pos_n = diff[8] ? 8'h00 : diff[7:0];
            if (pos_n == 8'h00) begin
              dir_n = 1'b1;
              rev   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    if (key_pulse && !rev) dir_n = ~dir;
  end

endmodule

// File: doc/servo_sweep_ctrl.md
# servo_sweep_ctrl

Position generator sitting directly upstream of the servo PWM controller: produces the 8-bit `position` word (0 = -90°, 8'h7F ≈ 0°, 8'hFF = +90°) that the PWM stage compares against its 18-bit frame counter. Updates position once per servo frame, either slew-limited tracking of a target value (DIP switches) or an automatic end-to-end sweep whose direction a debounced pushbutton can reverse. Keeps motion smooth and frame-aligned so the PWM stage never sees mid-frame jumps larger than `STEP`.

## Interface
- `FRAME_CYCLES`, 262144: clk cycles per update frame; matches the 18-bit PWM counter wrap at 12 MHz (~21.8 ms).
- `STEP`, 1: max position change per frame, range 1..255.
- `DEBOUNCE_CYCLES`, 120000: stable-level time required on `dir_key` (10 ms @ 12 MHz).

- `clk` in 1: system clock, 12 MHz.
- `rst` in 1: reset rst, synchronous, active-high; clock clk.
- `sweep_en` in 1: 1 = auto sweep, 0 = track `target`; sampled only on frame update.
- `target` in 8: tracking target (DIP switches), sampled only on frame update.
- `dir_key` in 1: raw asynchronous pushbutton, active-high.
- `position` out 8: registered position to PWM stage.
- `dir` out 1: current sweep direction, 1 = increasing.
- `frame_tick` out 1: one-cycle pulse, last cycle of each frame.

## Operation
- Frame counter `fcnt` counts 0..FRAME_CYCLES-1 and wraps; `frame_tick` = 1 when `fcnt == FRAME_CYCLES-1`.
- Key path: 2-flop synchroniser -> (debounce, see Configuration) -> rising-edge detect -> `key_pulse` (one cycle).
- FSM states: TRACK, SWEEP. On each `frame_tick` the next state is SWEEP if `sweep_en` else TRACK; the position update on that edge uses the new mode.
- TRACK update: d = target - position (9-bit signed); |d| <= STEP -> position = target; else position ± STEP toward target. Never overshoots. `dir` unchanged.
- SWEEP update, dir=1: position = min(position+STEP, 255) via 9-bit sum and saturation; result 255 -> dir <= 0. dir=0: position = max(position-STEP, 0); result 0 -> dir <= 1.
- `key_pulse` toggles `dir` in any state. Same-cycle conflict with an endpoint reversal: endpoint reversal wins; key pulse is dropped.
- Mode change TRACK<->SWEEP starts from current `position`; no jump.
- Outside `frame_tick` cycles `position` holds.

## Timing
- Reset values: position = 8'h7F, dir = 1, frame_tick = 0, fcnt = 0, state = TRACK, synchroniser/debounce state cleared to 0.
- First `frame_tick` in cycle FRAME_CYCLES-1 after reset release; period FRAME_CYCLES thereafter.
- `position` and `dir` change on the clk edge that samples `frame_tick` = 1 (visible the cycle after the pulse).
- Key latency to `dir` toggle: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles when debounce is enabled; 3 cycles when disabled.
- If a key toggle and a frame update coincide, the update uses the pre-toggle `dir`.
- `rst` mid-frame: all state returns to reset values on that edge; the frame restarts at fcnt = 0.

## Configuration
- `SERVO_SWEEP_DEBOUNCE_EN` defined: synchronised key level must remain stable for DEBOUNCE_CYCLES consecutive cycles before the debounced level updates; glitches shorter than this produce no `key_pulse`.
- Undefined: debounce counter is not built and `DEBOUNCE_CYCLES` is unused; every synchronised rising edge yields a `key_pulse`.

## Test plan
Bench parameters: FRAME_CYCLES=16, STEP=4, DEBOUNCE_CYCLES=8.
- Reset check: assert rst 3 cycles -> position=8'h7F, dir=1, frame_tick=0; first frame_tick exactly 15 cycles after release, then every 16.
- Tracking: sweep_en=0, target=8'h8A -> position 7F→83→87→8A over 3 frames, then holds at 8A; target=8'h00 -> decreases by 4 per frame with no underflow.
- Sweep saturation: sweep_en=1, preset position 8'hFD -> next frame FF with dir→0, following frame FB; from 8'h02 downward -> 00 with dir→1.
- Key reversal: sweep_en=1, dir=1, clean 20-cycle press -> dir=0 after 11 cycles (debounce on) or 3 cycles (off); next frame decreases position by 4.
- Conflict: key_pulse in the same cycle as the endpoint reversal at FF -> dir=0 (key dropped); 5-cycle glitch with debounce on -> no toggle.
- Mid-frame rst while sweeping at 8'h40 -> position 7F, dir 1, fcnt restarts at 0.
